// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode instruction FIFO with flush
// Circular buffer of {pc, word, fault}; wrap-bit pointers give full/empty and occupancy.
module instr_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [31:0]                fetch_data_i,
  input  logic                       fetch_fault_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic [31:0]                dec_data_o,
  output logic                       dec_fault_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_data  [DEPTH];
  logic            mem_fault [DEPTH];

  logic [AW:0]   rd_ptr, wr_ptr;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          empty, full, push, pop;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);

  // Ready depends on state only, so a full queue never accepts even when a pop is pending.
  assign fetch_ready_o = !full;
  assign dec_valid_o   = !empty;
  assign push          = fetch_valid_i & fetch_ready_o & !flush_i;
  assign pop           = dec_valid_o & dec_ready_i & !flush_i;
  assign count_o       = CW'(wr_ptr - rd_ptr);

  // Storage is unreset; the empty gate keeps stale contents off the outputs.
  assign dec_pc_o    = empty ? '0   : mem_pc[rd_idx];
  assign dec_data_o  = empty ? '0   : mem_data[rd_idx];
  assign dec_fault_o = empty ? 1'b0 : mem_fault[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_idx]    <= fetch_pc_i;
      mem_data[wr_idx]  <= fetch_data_i;
      mem_fault[wr_idx] <= fetch_fault_i;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);
  a_count_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni) count_o <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed and random checks of instr_queue against a queue model
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
    logic            fault;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, fv, fr, ff, dv, dr, df;
  logic [XLEN-1:0] fpc, dpc;
  logic [31:0]     fdata, ddata;
  logic [2:0]      count;

  int checks = 0;
  int errors = 0;
  entry_t model[$];

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fetch_valid_i(fv), .fetch_ready_o(fr), .fetch_pc_i(fpc),
    .fetch_data_i(fdata), .fetch_fault_i(ff),
    .dec_valid_o(dv), .dec_ready_i(dr), .dec_pc_o(dpc),
    .dec_data_o(ddata), .dec_fault_o(df), .count_o(count)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", XLEN'(dv), XLEN'(model.size() != 0));
    chk("ready", XLEN'(fr), XLEN'(model.size() < DEPTH));
    chk("count", XLEN'(count), XLEN'(model.size()));
    chk("pc",    dpc,           model.size() != 0 ? model[0].pc : '0);
    chk("data",  XLEN'(ddata),  model.size() != 0 ? XLEN'(model[0].data) : '0);
    chk("fault", XLEN'(df),     model.size() != 0 ? XLEN'(model[0].fault) : '0);
  endtask

  // One clock: decide the model's push/pop from pre-edge state and inputs, then compare.
  task automatic cycle();
    bit do_push, do_pop;
    entry_t e;
    do_push = fv && !flush && model.size() < DEPTH;
    do_pop  = dr && !flush && model.size() > 0;
    e.pc = fpc; e.data = fdata; e.fault = ff;
    @(posedge clk);
    if (flush) model.delete();
    else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(e);
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic r, input logic [XLEN-1:0] pc, input logic flt);
    fv = v; dr = r; fpc = pc; fdata = $urandom; ff = flt;
  endtask

  logic [XLEN-1:0] pc7;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(0, 0, '0, 0);
    #12;
    chk("rst_valid", XLEN'(dv), '0);
    chk("rst_ready", XLEN'(fr), XLEN'(1));
    chk("rst_count", XLEN'(count), '0);
    chk("rst_pc", dpc, '0);
    @(negedge clk); rst_n = 1'b1;

    // Fill with decoder stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 64'h8000_0000 + XLEN'(4 * i), 0);
      cycle();
    end
    chk("fill_count", XLEN'(count), XLEN'(4));
    chk("fill_ready", XLEN'(fr), '0);
    chk("fill_pc", dpc, 64'h8000_0000);
    drive(1, 0, 64'h9000_0000, 0);
    cycle();
    chk("fill_hold_pc", dpc, 64'h8000_0000);

    // Full + pop: pop only, then push+pop keeps count
    drive(1, 1, 64'h9000_0004, 0);
    cycle();
    chk("fullpop_count1", XLEN'(count), XLEN'(3));
    chk("fullpop_ready", XLEN'(fr), XLEN'(1));
    drive(1, 1, 64'h9000_0008, 0);
    cycle();
    chk("fullpop_count2", XLEN'(count), XLEN'(3));

    // Stream from empty
    flush = 1'b1; drive(0, 0, '0, 0); cycle(); flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 64'hA000_0000 + XLEN'(4 * i), 0);
      cycle();
      chk("stream_count", XLEN'(count), XLEN'(1));
      chk("stream_pc", dpc, 64'hA000_0000 + XLEN'(4 * i));
    end

    // Flush with a concurrent offer
    flush = 1'b1; drive(0, 0, '0, 0); cycle(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 64'hB000_0000 + XLEN'(4 * i), 0);
      cycle();
    end
    flush = 1'b1; drive(1, 1, 64'hDEAD_0000, 0);
    cycle();
    flush = 1'b0;
    chk("flush_valid", XLEN'(dv), '0);
    chk("flush_count", XLEN'(count), '0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, '0, 0);
      cycle();
      chk("flush_no_stale", XLEN'(dv), '0);
    end

    // Wrap with a fault on the 7th entry
    drive(1, 0, 64'hC000_0000, 0);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10 ? 1'b1 : 1'b0, 1, 64'hC000_0000 + XLEN'(4 * i), i == 6);
      cycle();
      if (dpc == 64'hC000_0018) chk("wrap_fault7", XLEN'(df), XLEN'(1));
      else chk("wrap_fault_other", XLEN'(df), '0);
    end

    // Async reset with two entries held
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 64'hE000_0000 + XLEN'(4 * i), 0);
      cycle();
    end
    drive(0, 0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    model.delete();
    chk("arst_valid", XLEN'(dv), '0);
    chk("arst_count", XLEN'(count), '0);
    chk("arst_ready", XLEN'(fr), XLEN'(1));
    chk("arst_pc", dpc, '0);
    @(negedge clk); rst_n = 1'b1;
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pc7 = {32'h0, $urandom};
      drive(1'($urandom), 1'($urandom_range(0, 3) != 0), pc7, 1'($urandom_range(0, 7) == 0));
      flush = ($urandom_range(0, 31) == 0);
      cycle();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
